// File: rtl/uart_receiver_if.sv
// Receive-side handshake between the UART receiver and the CPU memory-stage read mux.
// The receiver drives the data/status side (master); the consumer drives the pop (slave).
interface uart_receiver_if;
  logic [7:0] DataOut;
  logic       DataOutValid;
  logic       DataOutReady;
  logic       Overrun;
  logic       FrameErr;

  modport master (
    output DataOut,
    output DataOutValid,
    input  DataOutReady,
    output Overrun,
    output FrameErr
  );

  modport slave (
    input  DataOut,
    input  DataOutValid,
    output DataOutReady,
    input  Overrun,
    input  FrameErr
  );
endinterface

// File: rtl/uart_receiver.sv
// 8N1 UART receive stage: synchronizes SIn, recovers frames by mid-bit sampling and holds
// one byte for the CPU, flagging overrun (sticky) and framing errors (one-cycle pulse).
module uart_receiver #(
  parameter int ClockFreq = 50_000_000,
  parameter int BaudRate  = 115_200
) (
  input  logic            Clock,
  input  logic            Reset,
  input  logic            SIn,
  uart_receiver_if.master rxIf
);

  localparam int CyclesPerBit = ClockFreq / BaudRate;
  localparam int HalfBit      = CyclesPerBit / 2;
  localparam int CntW         = $clog2(CyclesPerBit) + 1;

  localparam logic [CntW-1:0] CntZero  = CntW'(0);
  localparam logic [CntW-1:0] CntOne   = CntW'(1);
  localparam logic [CntW-1:0] HalfLast = CntW'(HalfBit - 1);
  localparam logic [CntW-1:0] BitLast  = CntW'(CyclesPerBit - 1);

  typedef enum logic [1:0] {
    Idle  = 2'd0,
    Start = 2'd1,
    Data  = 2'd2,
    Stop  = 2'd3
  } state_e;

  logic            sinMeta_r;
  logic            sinSync_r;
  state_e          state_r;
  logic [CntW-1:0] cycleCnt_r;
  logic [2:0]      bitIdx_r;
  logic [7:0]      shiftReg_r;
  logic [7:0]      dataOut_r;
  logic            dataOutValid_r;
  logic            overrun_r;
  logic            frameErr_r;

  logic            pop_s;
  logic            halfDone_s;
  logic            bitDone_s;

  assign pop_s      = dataOutValid_r & rxIf.DataOutReady;
  assign halfDone_s = (cycleCnt_r == HalfLast);
  assign bitDone_s  = (cycleCnt_r == BitLast);

  assign rxIf.DataOut      = dataOut_r;
  assign rxIf.DataOutValid = dataOutValid_r;
  assign rxIf.Overrun      = overrun_r;
  assign rxIf.FrameErr     = frameErr_r;

  // Two-flop synchronizer for the asynchronous serial line; both stages idle high.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      sinMeta_r <= 1'b1;
      sinSync_r <= 1'b1;
    end else begin
      sinMeta_r <= SIn;
      sinSync_r <= sinMeta_r;
    end
  end

  // Frame recovery FSM together with the holding register and status outputs.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_r        <= Idle;
      cycleCnt_r     <= CntZero;
      bitIdx_r       <= 3'd0;
      shiftReg_r     <= 8'h00;
      dataOut_r      <= 8'h00;
      dataOutValid_r <= 1'b0;
      overrun_r      <= 1'b0;
      frameErr_r     <= 1'b0;
    end else begin
      frameErr_r <= 1'b0;

      // A pop empties the holder; a good stop bit below may refill it on the same edge.
      if (pop_s) begin
        dataOutValid_r <= 1'b0;
        overrun_r      <= 1'b0;
      end else begin
        dataOutValid_r <= dataOutValid_r;
        overrun_r      <= overrun_r;
      end

      case (state_r)
        Idle: begin
          cycleCnt_r <= CntZero;
          bitIdx_r   <= 3'd0;
          if (!sinSync_r) begin
            state_r <= Start;
          end else begin
            state_r <= Idle;
          end
        end

        Start: begin
          if (halfDone_s) begin
            cycleCnt_r <= CntZero;
            bitIdx_r   <= 3'd0;
            if (!sinSync_r) begin
              state_r <= Data;
            end else begin
              state_r <= Idle;
            end
          end else begin
            cycleCnt_r <= cycleCnt_r + CntOne;
          end
        end

        Data: begin
          if (bitDone_s) begin
            cycleCnt_r <= CntZero;
            shiftReg_r <= {sinSync_r, shiftReg_r[7:1]};
            if (bitIdx_r == 3'd7) begin
              state_r <= Stop;
            end else begin
              bitIdx_r <= bitIdx_r + 3'd1;
            end
          end else begin
            cycleCnt_r <= cycleCnt_r + CntOne;
          end
        end

        Stop: begin
          // Leave at mid-stop so a back-to-back start bit is never missed.
          if (bitDone_s) begin
            cycleCnt_r <= CntZero;
            state_r    <= Idle;
            if (sinSync_r) begin
              if (!dataOutValid_r || pop_s) begin
                dataOut_r      <= shiftReg_r;
                dataOutValid_r <= 1'b1;
              end else begin
                overrun_r <= 1'b1;
              end
            end else begin
              frameErr_r <= 1'b1;
            end
          end else begin
            cycleCnt_r <= cycleCnt_r + CntOne;
          end
        end

        default: begin
          state_r    <= Idle;
          cycleCnt_r <= CntZero;
          bitIdx_r   <= 3'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_receiver.sv
// Randomized scoreboard bench for uart_receiver: frame timing and contents are predicted from
// bit-period arithmetic, and a negedge monitor checks every byte presentation and error pulse.
module tb_uart_receiver;

  localparam int Cpb = 10;
  localparam int Hb  = 5;

  logic Clock = 1'b0;
  logic Reset;
  logic SIn;
  int   cyc = 0;

  uart_receiver_if rxIf ();

  uart_receiver #(
    .ClockFreq(1000),
    .BaudRate (100)
  ) dut (
    .Clock(Clock),
    .Reset(Reset),
    .SIn  (SIn),
    .rxIf (rxIf)
  );

  always #5 Clock = ~Clock;

  always @(posedge Clock) cyc <= cyc + 1;

  typedef struct {
    int         when;
    logic [7:0] data;
  } exp_t;

  exp_t expQ[$];
  int   ferrQ[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model of what the holding register should contain.
  logic       mValid;
  logic       mOverrun;
  logic [7:0] mData;

  // Monitor: every rising DataOutValid and every FrameErr cycle must match a prediction.
  initial begin : monitor
    logic prevValid;
    exp_t e;
    int   fe;
    prevValid = 1'b0;
    forever begin
      @(negedge Clock);
      if (rxIf.DataOutValid === 1'b1 && !prevValid) begin
        checks++;
        if (expQ.size() == 0) begin
          errors++;
          $display("FAIL rise_unexpected: cycle %0d data %02h, required no new byte", cyc, rxIf.DataOut);
        end else begin
          e = expQ.pop_front();
          if (cyc != e.when || rxIf.DataOut !== e.data) begin
            errors++;
            $display("FAIL rise: cycle %0d data %02h, required cycle %0d data %02h",
                     cyc, rxIf.DataOut, e.when, e.data);
          end
        end
      end
      if (rxIf.FrameErr === 1'b1) begin
        checks++;
        if (ferrQ.size() == 0) begin
          errors++;
          $display("FAIL ferr_unexpected: FrameErr high at cycle %0d, required low", cyc);
        end else begin
          fe = ferrQ.pop_front();
          if (cyc != fe) begin
            errors++;
            $display("FAIL ferr: pulse at cycle %0d, required cycle %0d", cyc, fe);
          end
        end
      end
      prevValid = (rxIf.DataOutValid === 1'b1);
    end
  end

  task automatic cmp(input string name, input logic [7:0] act, input logic [7:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %02h, required %02h", name, act, req);
    end
  endtask

  task automatic checkState(input string name);
    @(negedge Clock);
    cmp({name, "_valid"},   {7'd0, rxIf.DataOutValid}, {7'd0, mValid});
    cmp({name, "_overrun"}, {7'd0, rxIf.Overrun},      {7'd0, mOverrun});
    cmp({name, "_data"},    rxIf.DataOut,              mData);
    cmp({name, "_ferr"},    {7'd0, rxIf.FrameErr},     8'd0);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge Clock);
      #1;
    end
  endtask

  task automatic popOne();
    rxIf.DataOutReady = 1'b1;
    @(posedge Clock);
    #1;
    rxIf.DataOutReady = 1'b0;
    if (mValid) begin
      mValid   = 1'b0;
      mOverrun = 1'b0;
    end
  endtask

  // Drives one 8N1 frame; popAtStop raises DataOutReady on the stop-sample edge,
  // abortAt >= 0 asserts Reset at that bit-cycle and ends the frame there.
  task automatic sendFrame(input logic [7:0] b, input logic stopBit,
                           input logic popAtStop, input int abortAt);
    int         e;
    int         stopEdge;
    int         lastK;
    logic [9:0] bits;
    e        = cyc;
    stopEdge = e + 2 + 1 + Hb + 9 * Cpb;
    bits     = {stopBit, b, 1'b0};
    lastK    = (abortAt >= 0) ? abortAt : 10 * Cpb - 1;
    if (abortAt < 0) begin
      if (stopBit && !mValid) expQ.push_back('{stopEdge, b});
      if (!stopBit) ferrQ.push_back(stopEdge);
    end
    for (int k = 0; k <= lastK; k++) begin
      SIn = bits[k / Cpb];
      if (popAtStop && k == stopEdge - e - 1) rxIf.DataOutReady = 1'b1;
      if (popAtStop && k == stopEdge - e)     rxIf.DataOutReady = 1'b0;
      if (k == abortAt) Reset = 1'b1;
      @(posedge Clock);
      #1;
    end
    SIn = 1'b1;
    rxIf.DataOutReady = 1'b0;
    if (abortAt >= 0) begin
      mValid   = 1'b0;
      mOverrun = 1'b0;
      mData    = 8'h00;
    end else if (stopBit) begin
      if (!mValid) begin
        mValid = 1'b1;
        mData  = b;
      end else if (popAtStop) begin
        mData    = b;
        mOverrun = 1'b0;
      end else begin
        mOverrun = 1'b1;
      end
    end else if (popAtStop && mValid) begin
      mValid   = 1'b0;
      mOverrun = 1'b0;
    end
  endtask

  initial begin : stimulus
    logic [7:0] rb;
    logic       rstop;
    logic       rpop;
    Reset = 1'b1;
    SIn   = 1'b1;
    rxIf.DataOutReady = 1'b0;
    mValid   = 1'b0;
    mOverrun = 1'b0;
    mData    = 8'h00;
    idle(3);
    checkState("reset");
    Reset = 1'b0;
    idle(5);

    // Single frame held until popped.
    sendFrame(8'hA5, 1'b1, 1'b0, -1);
    checkState("t1_held");
    idle(7);
    checkState("t1_still");
    popOne();
    checkState("t1_pop");

    // Back-to-back frames without a pop: second one dropped, overrun set.
    sendFrame(8'h3C, 1'b1, 1'b0, -1);
    sendFrame(8'hC3, 1'b1, 1'b0, -1);
    checkState("t2_overrun");
    popOne();
    checkState("t2_pop");

    // Pop coinciding with a commit replaces the held byte.
    sendFrame(8'h11, 1'b1, 1'b0, -1);
    sendFrame(8'h7E, 1'b1, 1'b1, -1);
    checkState("t3_swap");
    popOne();
    checkState("t3_pop");

    // Bad stop bit then a good frame.
    sendFrame(8'h55, 1'b0, 1'b0, -1);
    idle(20);
    checkState("t4_ferr");
    sendFrame(8'h0F, 1'b1, 1'b0, -1);
    checkState("t4_next");
    popOne();

    // Short glitch shorter than half a bit.
    SIn = 1'b0;
    idle(3);
    SIn = 1'b1;
    idle(30);
    checkState("t5_glitch");
    sendFrame(8'h80, 1'b1, 1'b0, -1);
    checkState("t5_next");
    popOne();

    // Reset in the middle of a frame while a byte and overrun are held.
    sendFrame(8'hA0, 1'b1, 1'b0, -1);
    sendFrame(8'hB1, 1'b1, 1'b0, -1);
    checkState("t6_pre");
    sendFrame(8'hFF, 1'b1, 1'b0, 1 * Cpb + 4 * Cpb + Hb);
    checkState("t6_reset");
    Reset = 1'b0;
    idle(10);
    sendFrame(8'h01, 1'b1, 1'b0, -1);
    checkState("t6_next");
    popOne();
    checkState("t6_pop");

    // Randomized traffic with random gaps, pops and bad stop bits.
    for (int i = 0; i < 12; i++) begin
      rb    = 8'($urandom_range(0, 255));
      rstop = ($urandom_range(0, 3) != 0);
      rpop  = mValid && rstop && ($urandom_range(0, 2) == 0);
      sendFrame(rb, rstop, rpop, -1);
      checkState("rand");
      if (!rstop) idle(20);
      else idle($urandom_range(0, 12));
      if ($urandom_range(0, 1) == 1) begin
        popOne();
        checkState("rand_pop");
      end
    end

    idle(30);
    cmp("pending_bytes", 8'(expQ.size()), 8'd0);
    cmp("pending_ferr",  8'(ferrQ.size()), 8'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_receiver.md
Name: uart_receiver

Overview:
- Serial-to-parallel UART receive stage feeding the CPU's memory-stage UART read mux.
- Supplies the receiver data byte (read at 0x8000000C) and the receiver-valid status bit (read at 0x80000004).
- Recovers 8N1 frames from the asynchronous serial input and holds one byte until the CPU consumes it.
- Reports overrun and framing errors.

Parameters:
- ClockFreq, 50_000_000, system clock frequency in Hz.
- BaudRate, 115_200, serial bit rate.
- Derived, not overridable: CyclesPerBit = ClockFreq/BaudRate (integer truncation), HalfBit = CyclesPerBit/2 (truncation). Counter width is clog2(CyclesPerBit)+1.

Ports:
- Clock  in  1  system clock; all state updates on the rising edge.
- Reset  in  1  synchronous, active-high reset.
- SIn  in  1  asynchronous serial line; idles high.
- DataOut  out  8  received byte; stable while DataOutValid=1.
- DataOutValid  out  1  a byte is held and not yet consumed.
- DataOutReady  in  1  consumer pop; effective only in a cycle where DataOutValid=1.
- Overrun  out  1  sticky; a completed frame was dropped because the holding register was full.
- FrameErr  out  1  one-cycle pulse; the stop bit was sampled low.

Behaviour:
- Reset: state=IDLE, DataOut=0, DataOutValid=0, Overrun=0, FrameErr=0, counters=0, both synchronizer flops=1.
  - Reset mid-frame abandons the frame with no output activity.
  - Reset takes priority over every other event.
- Synchronizer: SIn passes through two flops; the FSM uses only the second flop (sin_s).
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: on sin_s==0 go to START and clear the cycle counter.
  - START: count cycles. At count==HalfBit-1, sample sin_s.
    - If 0, go to DATA with bit index 0 and the counter cleared.
    - If 1, treat as a glitch or false start and return to IDLE.
  - DATA: at count==CyclesPerBit-1, shift sin_s into the shift register LSB-first and clear the counter.
    - After bit index 7, go to STOP; otherwise increment the bit index.
  - STOP: at count==CyclesPerBit-1, sample sin_s and return to IDLE in the same edge.
    - Sample 1 is a good frame: commit the shift register.
    - Sample 0 is a bad frame: discard it and pulse FrameErr for exactly one cycle. DataOut, DataOutValid and Overrun are unchanged.
  - Returning to IDLE at mid-stop-bit is intentional, to tolerate baud mismatch. The line is high for the rest of the stop bit, so no false start occurs.
- Commit rules on a good stop bit:
  - DataOutValid==0: DataOut <= shift register, DataOutValid <= 1.
  - DataOutValid==1 with no pop this cycle: new byte dropped, DataOut unchanged, Overrun <= 1.
  - DataOutValid==1 with pop (DataOutReady=1) this cycle: pop and commit are simultaneous. DataOut <= new byte, DataOutValid stays 1, Overrun not set.
- Pop: DataOutReady=1 while DataOutValid=1 and no simultaneous commit clears DataOutValid on that edge. DataOut keeps its last value.
  - DataOutReady while DataOutValid=0 is ignored.
- Overrun is cleared by any pop, and by Reset.
  - If pop and a drop coincide, that is handled as the simultaneous pop+commit case above, so no drop occurs.
- Latency: the first edge where sin_s==0 in IDLE is cycle t0.
  - DataOutValid is first high at the edge t0 + 1 + HalfBit + 9*CyclesPerBit.
  - No additional pipeline delay is permitted.
  - SIn-to-sin_s adds 2 cycles.
- Back-to-back frames: a start bit arriving immediately after the stop bit must be received without loss. IDLE is re-entered at mid-stop.
- The receiver runs independently of DataOutValid. Reception never stalls; overrun only drops the new byte.

Test Plan:
All cases use ClockFreq=1000 and BaudRate=100 (CyclesPerBit=10, HalfBit=5).
1. Single frame 0xA5, good stop, DataOutReady=0 -> DataOutValid rises exactly 1+5+90 cycles after t0 with DataOut=0xA5. It stays high with Overrun=0 until DataOutReady=1 for one cycle, then DataOutValid=0 on the next edge.
2. Frames 0x3C then 0xC3 back-to-back, no pop -> DataOut=0x3C held, Overrun=1 after the second stop sample, 0xC3 dropped. One pop -> DataOutValid=0 and Overrun=0.
3. 0x11 held; DataOutReady=1 asserted exactly on the edge where the 0x7E stop bit is sampled -> DataOut=0x7E, DataOutValid remains 1, Overrun=0.
4. Frame 0x55 with stop bit driven 0 -> FrameErr high for exactly 1 cycle, DataOutValid stays 0, the next good frame 0x0F is received correctly.
5. SIn low pulse of 3 cycles (shorter than HalfBit) -> FSM returns to IDLE. No DataOutValid and no FrameErr; the following frame 0x80 is received as 0x80.
6. Reset asserted during data bit 4 of frame 0xFF -> all outputs at reset values next edge. After release, frame 0x01 is received as 0x01 with Overrun=0.
